// File: rtl/reaction_round_controller_if.sv
`default_nettype none
// =============================================================================
// reaction_round_controller_if
// Game-control and timer-control signals between the round controller and
// its environment (buttons, countdown timer, display).
// Revision: 1.0
// =============================================================================
interface reaction_round_controller_if #(
  parameter int MAX_MS     = 3000,
  parameter int ROUNDS     = 5,
  parameter int MAX_MISSES = 3
);
  logic                                 start;
  logic                                 hit;
  logic                                 pause;
  logic [$clog2(MAX_MS)-1:0]            timer_value;
  logic                                 end_reached;
  logic                                 timer_reset;
  logic                                 timer_enable;
  logic                                 round_active;
  logic [$clog2(ROUNDS+1)-1:0]          round_num;
  logic [$clog2(ROUNDS*MAX_MS+1)-1:0]   score;
  logic [$clog2(MAX_MISSES+1)-1:0]      misses;
  logic                                 game_over;

  modport master (
    output start, hit, pause, timer_value, end_reached,
    input  timer_reset, timer_enable, round_active, round_num, score, misses, game_over
  );

  modport slave (
    input  start, hit, pause, timer_value, end_reached,
    output timer_reset, timer_enable, round_active, round_num, score, misses, game_over
  );
endinterface
`default_nettype wire

// File: rtl/reaction_round_controller.sv
`default_nettype none
// =============================================================================
// reaction_round_controller
// Sequences a countdown timer through a multi-round reaction game and keeps
// score, round and miss counts.
// Revision: 1.0
// =============================================================================
module reaction_round_controller #(
  parameter int MAX_MS     = 3000,
  parameter int ROUNDS     = 5,
  parameter int MAX_MISSES = 3,
  parameter int GAP_CLKS   = 50
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  reaction_round_controller_if.slave bus
);
  localparam int c_TIMER_W = $clog2(MAX_MS);
  localparam int c_ROUND_W = $clog2(ROUNDS + 1);
  localparam int c_SCORE_W = $clog2(ROUNDS * MAX_MS + 1);
  localparam int c_MISS_W  = $clog2(MAX_MISSES + 1);
  localparam int c_GAP_W   = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  localparam logic [c_ROUND_W-1:0] c_ROUNDS_LAST = c_ROUND_W'(ROUNDS);
  localparam logic [c_MISS_W-1:0]  c_MISS_LAST   = c_MISS_W'(MAX_MISSES);
  localparam logic [c_GAP_W-1:0]   c_GAP_LAST    = c_GAP_W'(GAP_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_SCORE  = 3'd4,
    S_MISS   = 3'd5,
    S_GAP    = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t                 r_state;
  logic                   r_timer_reset;
  logic                   r_round_active;
  logic                   r_game_over;
  logic [c_ROUND_W-1:0]   r_round_num;
  logic [c_SCORE_W-1:0]   r_score;
  logic [c_MISS_W-1:0]    r_misses;
  logic [c_TIMER_W-1:0]   r_capture;
  logic [c_GAP_W-1:0]     r_gap;
  logic                   w_game_end;

  assign w_game_end = (r_round_num == c_ROUNDS_LAST) || (r_misses == c_MISS_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_timer_reset  <= 1'b1;
      r_round_active <= 1'b0;
      r_game_over    <= 1'b0;
      r_round_num    <= '0;
      r_score        <= '0;
      r_misses       <= '0;
      r_capture      <= '0;
      r_gap          <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state       <= S_LOAD;
            r_timer_reset <= 1'b1;
            r_game_over   <= 1'b0;
            r_round_num   <= '0;
            r_score       <= '0;
            r_misses      <= '0;
          end
        end
        S_LOAD: begin
          r_state       <= S_SETTLE;
          r_timer_reset <= 1'b0;
        end
        S_SETTLE: begin
          r_state        <= S_RUN;
          r_round_active <= 1'b1;
        end
        S_RUN: begin
          // Expiry wins over a simultaneous hit; a paused hit is dropped.
          if (bus.end_reached) begin
            r_state        <= S_MISS;
            r_round_active <= 1'b0;
          end else if (bus.hit && !bus.pause) begin
            r_state        <= S_SCORE;
            r_round_active <= 1'b0;
            r_capture      <= bus.timer_value;
          end
        end
        S_SCORE: begin
          r_state     <= S_GAP;
          r_score     <= r_score + c_SCORE_W'(r_capture);
          r_round_num <= r_round_num + c_ROUND_W'(1);
        end
        S_MISS: begin
          r_state     <= S_GAP;
          r_misses    <= r_misses + c_MISS_W'(1);
          r_round_num <= r_round_num + c_ROUND_W'(1);
        end
        S_GAP: begin
          if (r_gap == c_GAP_LAST) begin
            r_gap         <= '0;
            r_timer_reset <= 1'b1;
            if (w_game_end) begin
              r_state     <= S_DONE;
              r_game_over <= 1'b1;
            end else begin
              r_state     <= S_LOAD;
            end
          end else begin
            r_gap <= r_gap + c_GAP_W'(1);
          end
        end
        default: begin
          r_state        <= S_IDLE;
          r_timer_reset  <= 1'b1;
          r_round_active <= 1'b0;
          r_game_over    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.timer_reset  = r_timer_reset;
  assign bus.timer_enable = r_round_active & ~bus.pause;
  assign bus.round_active = r_round_active;
  assign bus.round_num    = r_round_num;
  assign bus.score        = r_score;
  assign bus.misses       = r_misses;
  assign bus.game_over    = r_game_over;

endmodule
`default_nettype wire

// File: doc/reaction_round_controller.md
Name: reaction_round_controller

Overview:
Sequences a countdown_timer instance through a multi-round reaction game. Each round resets and starts the timer, then waits for a player hit or timeout, and accumulates the remaining milliseconds as score. Sits between the debounced button/switch inputs and the timer and display logic. It owns the timer's reset and enable inputs.

Parameters:
MAX_MS, 3000, timer start value in ms; must match the attached timer.
ROUNDS, 5, rounds per game.
MAX_MISSES, 3, misses that end the game early.
GAP_CLKS, 50, inter-round gap in clk cycles (simulation value; hardware 50000000).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high; returns block to IDLE
start  input  1  single-cycle pulse; starts a new game from IDLE or DONE
hit  input  1  single-cycle pulse, debounced player button
pause  input  1  level; freezes the running round
timer_value  input  $clog2(MAX_MS)  current timer value from the timer
end_reached  input  1  timer expiry flag
timer_reset  output  1  drives the timer's reset input
timer_enable  output  1  drives the timer's enable input
round_active  output  1  high while in RUN (drives the prompt LED)
round_num  output  $clog2(ROUNDS+1)  rounds completed
score  output  $clog2(ROUNDS*MAX_MS+1)  accumulated remaining ms
misses  output  $clog2(MAX_MISSES+1)  rounds lost to timeout
game_over  output  1  high in DONE

Behaviour:
- State encoding: IDLE, LOAD, SETTLE, RUN, SCORE, MISS, GAP, DONE.
- Reset: state=IDLE. round_num, score and misses are 0. timer_reset=1 (the timer is held in reset while idle). timer_enable, round_active and game_over are 0. The gap counter is 0.
- Outputs are decoded from registered state, so they are valid in the cycle the state is entered.
- IDLE: timer_reset=1. On start, clear the counters and go to LOAD.
- LOAD: one cycle with timer_reset=1 and timer_enable=0. Then go to SETTLE.
- SETTLE: one cycle with both timer controls low. The timer now reads MAX_MS with end_reached=0. Then go to RUN.
- RUN: round_active=1 and timer_enable=!pause. Priority within one cycle:
  1. end_reached=1 → MISS. This applies even if hit is also 1 in the same cycle.
  2. hit=1 and pause=0 → SCORE.
  3. A hit while paused is ignored.
  4. start is ignored.
- SCORE: one cycle. score += the timer_value sampled on the RUN cycle that saw the hit; the implementation registers that capture. round_num += 1. timer_enable=0. Then go to GAP.
- MISS: one cycle. misses += 1, round_num += 1, timer_enable=0. Then go to GAP.
- GAP: count GAP_CLKS cycles with the timer disabled. Exit when the count reaches GAP_CLKS-1:
  - go to DONE if round_num==ROUNDS or misses==MAX_MISSES;
  - otherwise go to LOAD.
  - The gap counter clears on exit.
- DONE: game_over=1 and timer_reset=1. score, round_num and misses hold. On start, clear the counters and go to LOAD.
- Arithmetic: the score width cannot overflow, since at most ROUNDS×MAX_MS is added. round_num never exceeds ROUNDS and misses never exceeds MAX_MISSES.
- Pause: toggling pause in any state other than RUN has no effect. Pause in RUN only freezes timer_enable; end_reached is still honoured.
- reset asserted in any state, including mid-RUN, returns to IDLE within one cycle with all reset values.

Test Plan:
Common parameters: MAX_MS=20, CLKS_PER_MS=5 on the timer, ROUNDS=3, MAX_MISSES=2, GAP_CLKS=4.
- Reset then idle: assert reset for 2 cycles, then hold for 10 cycles → state IDLE, timer_reset=1, score=0, round_num=0, game_over=0.
- Single hit: start, then pulse hit when timer_value=15 → SCORE one cycle later, score=15, round_num=1, timer_enable=0; LOAD re-entered after exactly 4 GAP cycles.
- Timeout: start, no hit → end_reached arrives about 105 clks after SETTLE; misses=1, round_num=1, score unchanged.
- Simultaneous: hit on the same cycle as end_reached → MISS taken, score unchanged, misses+1.
- Pause: hold pause for 30 cycles mid-RUN → timer_value frozen, timer_enable=0; a hit during pause is ignored; release pause and hit at timer_value=10 → score+10.
- Game end: after 3 rounds, or after 2 misses (game ends after round 2) → DONE, game_over=1, counters held; start → counters cleared, LOAD.
